// File: rtl/seg_code_pkg.sv
// Seven-segment link code table and receiver state encoding, shared by the
// transmit-side encoder and the receive-side decoder.
package seg_code_pkg;

  // Word layout is {seg[6:0], dpt}; digit n clears seg bit n.
  localparam logic [7:0] SEG_D0    = 8'hFD;
  localparam logic [7:0] SEG_D1    = 8'hFB;
  localparam logic [7:0] SEG_D2    = 8'hF7;
  localparam logic [7:0] SEG_D3    = 8'hEF;
  localparam logic [7:0] SEG_D4    = 8'hDF;
  localparam logic [7:0] SEG_D5    = 8'hBF;
  localparam logic [7:0] SEG_ERR   = 8'h80;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HOLD  = 2'd2
  } rx_state_e;

  // Builds a link word from its segment and decimal-point parts.
  function automatic logic [7:0] seg_word(input logic [6:0] seg, input logic dpt);
    return {seg, dpt};
  endfunction

endpackage

// File: rtl/seg_code_decode.sv
// Combinational classifier of a link word into digit / error code / blank,
// anything not matched is treated as illegal by the caller.
module seg_code_decode
  import seg_code_pkg::*;
(
  input  logic [7:0] word,
  output logic       is_digit,
  output logic       is_err,
  output logic       is_blank,
  output logic [3:0] digit
);

  // Table lookup of the received word.
  always_comb begin
    is_digit = 1'b0;
    is_err   = 1'b0;
    is_blank = 1'b0;
    digit    = 4'd0;
    case (word)
      SEG_D0:    begin is_digit = 1'b1; digit = 4'd0; end
      SEG_D1:    begin is_digit = 1'b1; digit = 4'd1; end
      SEG_D2:    begin is_digit = 1'b1; digit = 4'd2; end
      SEG_D3:    begin is_digit = 1'b1; digit = 4'd3; end
      SEG_D4:    begin is_digit = 1'b1; digit = 4'd4; end
      SEG_D5:    begin is_digit = 1'b1; digit = 4'd5; end
      SEG_ERR:   is_err   = 1'b1;
      SEG_BLANK: is_blank = 1'b1;
      default:   digit    = 4'd0;
    endcase
  end

endmodule

// File: rtl/seg_to_num_rx.sv
// Receive end of the seven-segment digit link: synchronizes the remote word,
// waits for it to settle, then reports it once as digit, error code or illegal.
module seg_to_num_rx
  import seg_code_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg_in,
  input  logic             dpt_in,
  input  logic             clr_cnt,
  output logic [3:0]       num_out,
  output logic             num_valid,
  output logic             err_code,
  output logic             illegal,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0]    STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [7:0]    sync_a;
  logic [7:0]    sync_b;
  logic [7:0]    w_q;
  logic [SW-1:0] stab_cnt;
  rx_state_e     state;

  logic       is_digit;
  logic       is_err;
  logic       is_blank;
  logic [3:0] digit;
  logic       decode_fire;
  logic       err_event;

  seg_code_decode u_decode (
    .word     (w_q),
    .is_digit (is_digit),
    .is_err   (is_err),
    .is_blank (is_blank),
    .digit    (digit)
  );

  // Two-flop synchronizer; idles at blank so reset never looks like a new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= SEG_BLANK;
      sync_b <= SEG_BLANK;
    end else begin
      sync_a <= seg_word(seg_in, dpt_in);
      sync_b <= sync_a;
    end
  end

  // Decode happens on the single cycle the settled word completes its count.
  always_comb begin
    decode_fire = (state == ST_TRACK) && (sync_b == w_q) && (stab_cnt == STAB_LAST);
    err_event   = decode_fire && !is_blank && !is_digit;
  end

  // Stability tracking FSM with registered result pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q       <= SEG_BLANK;
      stab_cnt  <= '0;
      state     <= ST_IDLE;
      num_out   <= 4'd0;
      num_valid <= 1'b0;
      err_code  <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      num_valid <= 1'b0;
      err_code  <= 1'b0;
      illegal   <= 1'b0;
      if (sync_b != w_q) begin
        w_q      <= sync_b;
        stab_cnt <= '0;
        state    <= ST_TRACK;
      end else begin
        case (state)
          ST_TRACK: begin
            if (stab_cnt == STAB_LAST) begin
              if (is_blank) begin
                state <= ST_IDLE;
              end else begin
                state <= ST_HOLD;
                if (is_digit) begin
                  num_out   <= digit;
                  num_valid <= 1'b1;
                end else if (is_err) begin
                  err_code <= 1'b1;
                end else begin
                  illegal <= 1'b1;
                end
              end
            end else begin
              stab_cnt <= stab_cnt + SW'(1);
            end
          end
          ST_IDLE: state <= ST_IDLE;
          ST_HOLD: state <= ST_HOLD;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Saturating error counter; a clear wins over a coincident error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt <= '0;
    end else if (err_event && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end else begin
      err_cnt <= err_cnt;
    end
  end

endmodule

// File: tb/tb_seg_to_num_rx.sv
// Self-checking bench for seg_to_num_rx: directed scenarios plus random words,
// all compared against a sample-history reference model.
module tb_seg_to_num_rx;

  localparam int STABLE = 4;
  localparam int CW     = 2;
  localparam int CMAX   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    seg_in;
  logic          dpt_in;
  logic          clr_cnt;
  logic [3:0]    num_out;
  logic          num_valid;
  logic          err_code;
  logic          illegal;
  logic [CW-1:0] err_cnt;

  int n_total = 0;
  int n_pass  = 0;
  int pulses  = 0;
  int m_num   = 0;
  int m_cnt   = 0;
  logic [7:0] hist[$];

  seg_to_num_rx #(.STABLE_CYCLES(STABLE), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_in    (seg_in),
    .dpt_in    (dpt_in),
    .clr_cnt   (clr_cnt),
    .num_out   (num_out),
    .num_valid (num_valid),
    .err_code  (err_code),
    .illegal   (illegal),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] samp(input int k);
    return (k < 0) ? 8'hFF : hist[k];
  endfunction

  // Digit n is all ones with seg bit n (word bit n+1) cleared and dpt set.
  function automatic int digit_of(input logic [7:0] w);
    logic [7:0] d;
    for (int n = 0; n < 6; n++) begin
      d = ~(8'd2 << n);
      if (w == d) return n;
    end
    return -1;
  endfunction

  function automatic logic [7:0] digit_word(input int n);
    logic [7:0] d;
    d = ~(8'd2 << n);
    return d;
  endfunction

  // A word seen at the pins for STABLE+1 consecutive samples starting a new run
  // is reported right after the edge STABLE+2 samples after the run began.
  task automatic step(input logic [7:0] w, input logic c);
    logic [2:0] exp_p;
    logic [7:0] w0;
    logic       fire;
    int         k0;
    seg_in  = w[7:1];
    dpt_in  = w[0];
    clr_cnt = c;
    @(posedge clk);
    hist.push_back(w);
    exp_p = 3'b000;
    fire  = 1'b0;
    k0    = hist.size() - 1 - STABLE - 2;
    if (k0 >= 0) begin
      w0   = hist[k0];
      fire = (samp(k0 - 1) != w0);
      for (int i = 1; i <= STABLE; i++)
        if (hist[k0 + i] != w0) fire = 1'b0;
      if (fire && w0 != 8'hFF) begin
        if (digit_of(w0) >= 0) begin
          exp_p = 3'b100;
          m_num = digit_of(w0);
        end else if (w0 == 8'h80) exp_p = 3'b010;
        else exp_p = 3'b001;
      end
    end
    if (c) m_cnt = 0;
    else if (exp_p[1:0] != 2'b00 && m_cnt < CMAX) m_cnt++;
    #1;
    if (num_valid) pulses++;
    chk("pulses",  {29'd0, num_valid, err_code, illegal}, {29'd0, exp_p});
    chk("num_out", {28'd0, num_out}, 32'(m_num));
    chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
  endtask

  task automatic do_reset(input int n);
    seg_in  = 7'h7F;
    dpt_in  = 1'b1;
    clr_cnt = 1'b0;
    rst     = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_out", {20'd0, num_out, num_valid, err_code, illegal, 5'd0, 32'(err_cnt)}, 32'd0);
    rst = 1'b0;
    hist.delete();
    m_num = 0;
    m_cnt = 0;
  endtask

  initial begin
    logic [7:0] w;
    int hold;
    int r;
    seg_in  = 7'h7F;
    dpt_in  = 1'b1;
    clr_cnt = 1'b0;
    rst     = 1'b1;
    #1;
    do_reset(3);

    // Idle after reset: blank only, nothing reported.
    pulses = 0;
    repeat (20) step(8'hFF, 1'b0);
    chk("idle_pulses", 32'(pulses), 32'd0);

    // Digit 1 held long: one report, never repeated.
    pulses = 0;
    repeat (12) step(digit_word(1), 1'b0);
    chk("d1_pulses", 32'(pulses), 32'd1);
    chk("d1_num", {28'd0, num_out}, 32'd1);

    // Short-lived digit 3 is dropped, digit 5 follows.
    pulses = 0;
    repeat (3) step(digit_word(3), 1'b0);
    repeat (10) step(digit_word(5), 1'b0);
    chk("d5_pulses", 32'(pulses), 32'd1);
    chk("d5_num", {28'd0, num_out}, 32'd5);

    // Error code and illegal word after digit 2.
    repeat (8) step(digit_word(2), 1'b0);
    repeat (8) step(8'h80, 1'b0);
    chk("err_num", {28'd0, num_out}, 32'd2);
    chk("err_cnt1", 32'(err_cnt), 32'd1);
    repeat (8) step(8'hAB, 1'b0);
    chk("ill_cnt2", 32'(err_cnt), 32'd2);
    chk("ill_num", {28'd0, num_out}, 32'd2);

    // Saturation, then clear coincident with a sixth illegal report.
    do_reset(2);
    for (int i = 0; i < 5; i++) begin
      repeat (8) step(8'hAB, 1'b0);
      repeat (2) step(8'hFF, 1'b0);
    end
    chk("sat_cnt", 32'(err_cnt), 32'(CMAX));
    repeat (6) step(8'hAB, 1'b0);
    step(8'hAB, 1'b1);
    chk("clr_ill", {31'd0, illegal}, 32'd1);
    chk("clr_cnt", 32'(err_cnt), 32'd0);
    repeat (3) step(8'hAB, 1'b0);
    chk("clr_hold", 32'(err_cnt), 32'd0);

    // Reset in the middle of tracking digit 4.
    repeat (3) step(8'hFF, 1'b0);
    repeat (5) step(digit_word(4), 1'b0);
    do_reset(2);
    pulses = 0;
    repeat (10) step(8'hFF, 1'b0);
    chk("mid_rst_pulses", 32'(pulses), 32'd0);
    chk("mid_rst_num", {28'd0, num_out}, 32'd0);
    pulses = 0;
    repeat (10) step(digit_word(4), 1'b0);
    chk("d4_pulses", 32'(pulses), 32'd1);
    chk("d4_num", {28'd0, num_out}, 32'd4);

    // Random words and hold times, occasional clears and resets.
    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 9);
      if (r < 6) w = digit_word(r);
      else if (r == 6) w = 8'h80;
      else if (r == 7) w = 8'hFF;
      else w = 8'($urandom);
      hold = $urandom_range(1, 9);
      for (int h = 0; h < hold; h++)
        step(w, ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 29) == 0) do_reset(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
